muldiv_iter: RTL and testbench

MULDIV_ITER -- requirements
Module: muldiv_iter

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_sign_fix.sv | 15 +
 rtl/muldiv_iter.sv | 168 ++++++++++++++++
 tb/tb_muldiv_iter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op select values and FSM states.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIVU) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; used for operand absolute value and result sign fixup.
module mdu_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_val,
  input  logic         i_neg,
  output logic [N-1:0] o_val
);

  always_comb begin
    o_val = i_val;
    if (i_neg) o_val = ~i_val + N'(1);
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide, one step per cycle.
module muldiv_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o,
  output logic               dbz_o
);

  mdu_state_e         r_state;
  mdu_state_e         w_state_nx;
  mdu_op_e            r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_md;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz;
  logic [2*WIDTH-1:0] r_result;

  mdu_op_e            w_op_in;
  logic               w_in_signed;
  logic               w_in_div;
  logic               w_dbz_in;
  logic               w_accept;
  logic               w_last_step;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;

  logic               w_is_div;
  logic [WIDTH:0]     w_add_a;
  logic [WIDTH:0]     w_add_b;
  logic [WIDTH+1:0]   w_sum;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_hi_nx;
  logic [WIDTH-1:0]   w_lo_nx;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_final;

  assign w_op_in     = mdu_op_e'(op_i);
  assign w_in_signed = op_is_signed(w_op_in);
  assign w_in_div    = op_is_div(w_op_in);
  assign w_dbz_in    = w_in_div && (opdata2_i == '0);
  assign w_accept    = (r_state == ST_IDLE) && start_i && !annul_i;
  assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_is_div    = op_is_div(r_op);

  mdu_sign_fix #(.N(WIDTH)) u_abs1 (
    .i_val (opdata1_i),
    .i_neg (w_in_signed && opdata1_i[WIDTH-1]),
    .o_val (w_abs1)
  );

  mdu_sign_fix #(.N(WIDTH)) u_abs2 (
    .i_val (opdata2_i),
    .i_neg (w_in_signed && opdata2_i[WIDTH-1]),
    .o_val (w_abs2)
  );

  // One shared WIDTH+1 adder/subtractor; the extra top bit of w_sum is the divide borrow.
  always_comb begin
    w_add_a = w_is_div ? {r_hi, r_lo[WIDTH-1]} : {1'b0, r_hi};
    w_add_b = (w_is_div || r_lo[0]) ? {1'b0, r_md} : '0;
    w_sum   = {1'b0, w_add_a}
            + (w_is_div ? ~{1'b0, w_add_b} : {1'b0, w_add_b})
            + {{(WIDTH+1){1'b0}}, w_is_div};
    w_borrow = w_sum[WIDTH+1];
    if (w_is_div) begin
      w_hi_nx = w_borrow ? w_add_a[WIDTH-1:0] : w_sum[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], ~w_borrow};
    end else begin
      w_hi_nx = w_sum[WIDTH:1];
      w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  mdu_sign_fix #(.N(2*WIDTH)) u_fix_prod (
    .i_val ({r_hi, r_lo}),
    .i_neg (r_neg_q),
    .o_val (w_prod)
  );

  mdu_sign_fix #(.N(WIDTH)) u_fix_quo (
    .i_val (r_lo),
    .i_neg (r_neg_q),
    .o_val (w_quo)
  );

  mdu_sign_fix #(.N(WIDTH)) u_fix_rem (
    .i_val (r_hi),
    .i_neg (r_neg_r),
    .o_val (w_rem)
  );

  always_comb begin
    w_final = w_prod;
    if (r_dbz)         w_final = {r_hi, {WIDTH{1'b1}}};
    else if (w_is_div) w_final = {w_rem, w_quo};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nx = w_dbz_in ? ST_DONE : ST_CALC;
      ST_CALC: if (w_last_step) w_state_nx = ST_DONE;
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
    if (annul_i) w_state_nx = ST_IDLE;

    // Outputs are gated by rst/annul so a flushed DONE cycle never presents a result.
    ready_o  = (r_state == ST_DONE) && !rst && !annul_i;
    dbz_o    = ready_o && r_dbz;
    stall_o  = !rst && (w_accept || (r_state == ST_CALC));
    result_o = ready_o ? w_final : r_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= MDU_MULTU;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_md     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= w_op_in;
        r_cnt   <= '0;
        r_md    <= w_abs2;
        r_lo    <= w_abs1;
        r_hi    <= w_dbz_in ? opdata1_i : '0;
        r_dbz   <= w_dbz_in;
        r_neg_q <= w_in_signed && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
        r_neg_r <= w_in_signed && opdata1_i[WIDTH-1];
      end else if (r_state == ST_CALC) begin
        r_hi  <= w_hi_nx;
        r_lo  <= w_lo_nx;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == ST_DONE) && !annul_i) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (WIDTH=32): arithmetic reference model plus directed vectors.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;
  logic        dbz_o;

  int n_vec = 0;
  int n_err = 0;

  muldiv_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stall_o   (stall_o),
    .dbz_o     (dbz_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer operators with C-style truncating signed divide.
  function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint p;
    int     sa, sb, q, r;
    logic [31:0] uq, ur;
    p = 0; sa = a; sb = b; q = 0; r = 0; uq = '0; ur = '0;
    case (op)
      2'b00: return {32'h0, a} * {32'h0, b};
      2'b01: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = a / b; ur = a % b;
        return {ur, uq};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb; r = sa % sb;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  logic        m_armed = 1'b0;
  logic        m_act   = 1'b0;
  int          m_cnt   = 0;
  int          m_lat   = 0;
  logic        m_dbz   = 1'b0;
  logic [63:0] m_exp   = '0;
  logic [63:0] m_last  = '0;

  always @(posedge clk) begin
    m_armed <= 1'b1;
    if (rst) begin
      m_act  <= 1'b0;
      m_last <= '0;
    end else if (annul_i) begin
      m_act <= 1'b0;
    end else if (m_act) begin
      if (m_cnt == m_lat) begin
        m_last <= m_exp;
        m_act  <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (start_i) begin
      m_act <= 1'b1;
      m_cnt <= 1;
      m_dbz <= op_i[1] && (opdata2_i == 0);
      m_lat <= (op_i[1] && (opdata2_i == 0)) ? 1 : 33;
      m_exp <= model_res(op_i, opdata1_i, opdata2_i);
    end
  end

  always @(negedge clk) begin
    logic e_ready, e_stall, e_dbz;
    logic [63:0] e_res;
    if (m_armed) begin
      e_ready = m_act && (m_cnt == m_lat) && !annul_i && !rst;
      e_stall = !rst && ((!m_act && start_i && !annul_i) || (m_act && (m_cnt < m_lat)));
      e_dbz   = e_ready && m_dbz;
      e_res   = e_ready ? m_exp : m_last;
      chk("model ready_o", 64'(ready_o), 64'(e_ready));
      chk("model stall_o", 64'(stall_o), 64'(e_stall));
      chk("model dbz_o",   64'(dbz_o),   64'(e_dbz));
      chk("model result_o", result_o, e_res);
    end
  end

  // Assumes start_i was raised in the current cycle; waits for ready_o and checks literals.
  task automatic wait_done(input string name, input logic [63:0] exp, input logic exp_dbz,
                           input int exp_lat);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready_o) begin
        lat = k;
        break;
      end
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    if (lat != 0) begin
      chk({name, " result"}, result_o, exp);
      chk({name, " dbz"}, 64'(dbz_o), 64'(exp_dbz));
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input logic exp_dbz,
                        input int exp_lat);
    @(posedge clk); #1;
    op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    wait_done(name, exp, exp_dbz, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1 start_i = 1'b1;
    @(negedge clk);
    chk("reset result_o", result_o, 64'h0);
    chk("reset ready/stall/dbz", {61'h0, ready_o, stall_o, dbz_o}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;

    run_op("DIV 7/-2",       2'b11, 32'd7,        32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 1'b0, 33);
    run_op("MULT -3*5",      2'b01, 32'hFFFF_FFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0, 33);
    run_op("MULTU max*max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, 1'b0, 33);
    run_op("DIVU x/0",       2'b10, 32'h0000_1234, 32'h0,        64'h00001234_FFFFFFFF, 1'b1, 1);
    run_op("DIV min/-1",     2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0, 33);
    run_op("DIV -7/2",       2'b11, 32'hFFFF_FFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 33);
    run_op("MULT min*min",   2'b01, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, 1'b0, 33);
    run_op("DIV neg/0",      2'b11, 32'hFFFF_FFF0, 32'h0,        64'hFFFFFFF0_FFFFFFFF, 1'b1, 1);
    run_op("MULTU 0*n",      2'b00, 32'h0,        32'd12345,     64'h0, 1'b0, 33);
    run_op("DIVU 100/7",     2'b10, 32'd100,      32'd7,         64'h00000002_0000000E, 1'b0, 33);

    // Annul a DIV at cycle +10, then start MULTU 3*4 in the following IDLE cycle.
    @(posedge clk); #1;
    op_i = 2'b11; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    chk("annul no ready", 64'(ready_o), 64'h0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    op_i = 2'b00; opdata1_i = 32'd3; opdata2_i = 32'd4; start_i = 1'b1;
    @(negedge clk);
    chk("annul result held", result_o, 64'h00000002_0000000E);
    chk("annul idle stall", 64'(stall_o), 64'h1);
    wait_done("MULTU 3*4 after annul", 64'd12, 1'b0, 33);

    // Reset at cycle +5 of a MULT, then a normal MULT.
    @(posedge clk); #1;
    op_i = 2'b01; opdata1_i = 32'hFFFF_FFFD; opdata2_i = 32'd5; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst mid-op result", result_o, 64'h0);
    chk("rst mid-op flags", {61'h0, ready_o, stall_o, dbz_o}, 64'h0);
    run_op("MULT after rst", 2'b01, 32'hFFFF_FFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 33);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
